// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the data path,
// data first with a starvation guard for fetch. Optional MEM_ARB_TIMEOUT_EN adds a WAIT-state watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ready,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ready,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_error,
    output logic [2:0]        dbg_state,
    output logic [3:0]        dbg_starve_cnt
);

    // Handshakes: a requester holds x_req and its fields until it sees x_ready high at a clock edge;
    // mem_req and its fields are held until mem_ready; mem_valid and x_valid are single-cycle pulses.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       grant_i;
    logic       grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013);

    logic [WD_W-1:0] wd_cnt;
`else
    assign bus_error = 1'b0;
`endif

    // Grants are only offered from IDLE and never while reset is held.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (reset && state == IDLE) begin
            grant_i = inst_req && (!data_req || starve_cnt == STARVE_LIM);
            grant_d = data_req && !grant_i;
        end
    end

    assign inst_ready     = grant_i;
    assign data_ready     = grant_d;
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_valid <= 1'b0;
            inst_rdata <= '0;
            data_valid <= 1'b0;
            data_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            bus_error  <= 1'b0;
`endif
        end else begin
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_error  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state      <= REQ_I;
                        starve_cnt <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_wstrb  <= '0;
                        mem_addr   <= inst_addr;
                        mem_wdata  <= '0;
                    end else if (grant_d) begin
                        state <= REQ_D;
                        if (inst_req && starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        mem_req   <= 1'b1;
                        mem_we    <= data_we;
                        mem_wstrb <= data_wstrb;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_wdata;
                    end
                end
                REQ_I: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT_I;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                REQ_D: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT_D;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (mem_valid) begin
                        if (state == WAIT_I) begin
                            inst_valid <= 1'b1;
                            inst_rdata <= mem_rdata;
                        end else begin
                            data_valid <= 1'b1;
                            data_rdata <= mem_rdata;
                        end
                        state <= IDLE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // A stalled response completes with a benign value so the pipeline keeps moving.
                    else if (wd_cnt == WD_LAST) begin
                        bus_error <= 1'b1;
                        if (state == WAIT_I) begin
                            inst_valid <= 1'b1;
                            inst_rdata <= NOP_WORD;
                        end else begin
                            data_valid <= 1'b1;
                            data_rdata <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (grant order, memory fields, response routing, latency).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int STARVE_MAX     = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              inst_req = 1'b0;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic              inst_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req = 1'b0;
    logic              data_we = 1'b0;
    logic [3:0]        data_wstrb = '0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [DATA_W-1:0] data_wdata = '0;
    logic              data_ready;
    logic              data_valid;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 1'b0;
    logic              mem_valid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              bus_error;
    logic [2:0]        dbg_state;
    logic [3:0]        dbg_starve_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .inst_valid(inst_valid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ready(data_ready), .data_valid(data_valid), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .bus_error(bus_error), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    typedef struct packed {
        logic              is_inst;
        logic              we;
        logic [3:0]        wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // requester stimulus state
    logic              inst_pend = 1'b0;
    logic [ADDR_W-1:0] inst_addr_v = '0;
    logic              data_pend = 1'b0;
    logic              data_we_v = 1'b0;
    logic [3:0]        data_wstrb_v = '0;
    logic [ADDR_W-1:0] data_addr_v = '0;
    logic [DATA_W-1:0] data_wdata_v = '0;
    int inst_rate = 0;
    int data_rate = 0;
    int data_left = 0;

    // memory responder knobs
    int   rdy_fix = 0;
    int   resp_fix = 0;
    int   rdy_cnt = 0;
    int   resp_cnt = 0;
    logic stray_en = 1'b0;
    logic rdata_fix_en = 1'b0;
    logic [DATA_W-1:0] rdata_fix = '0;

    // reference model
    logic              busy = 1'b0;
    logic              exp_mem_req = 1'b0;
    logic              mem_wait = 1'b0;
    logic              exp_berr = 1'b0;
    int                starve = 0;
    int                wcount = 0;
    int                grant_cyc = 0;
    int                lat_last = 0;
    int                mreq_cycles = 0;
    int                n_dvalid = 0;
    int                n_berr = 0;
    txn_t              cur = '0;
    logic [DATA_W-1:0] last_inst_rd = '0;
    logic [DATA_W-1:0] last_data_rd = '0;
    logic [DATA_W-1:0] exp_inst_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [4:0]        grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_rdy();
        return (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(3));
    endfunction

    function automatic int pick_resp();
        return (resp_fix >= 0) ? resp_fix : int'($urandom_range(3));
    endfunction

    task automatic reset_model();
        busy = 1'b0; exp_mem_req = 1'b0; mem_wait = 1'b0; exp_berr = 1'b0;
        starve = 0; last_inst_rd = '0; last_data_rd = '0;
        inst_pend = 1'b0; data_pend = 1'b0;
        exp_inst_q.delete(); exp_data_q.delete();
    endtask

    task automatic post_inst(input logic [ADDR_W-1:0] a);
        inst_pend = 1'b1; inst_addr_v = a;
    endtask

    task automatic post_data(input logic we, input logic [3:0] st, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd);
        data_pend = 1'b1; data_we_v = we; data_wstrb_v = st; data_addr_v = a; data_wdata_v = wd;
    endtask

    // Drive all DUT inputs shortly after the active edge.
    task automatic drive();
        if (!inst_pend && inst_rate > 0 && int'($urandom_range(99)) < inst_rate) begin
            inst_pend = 1'b1; inst_addr_v = $urandom & 32'hFFFF_FFFC;
        end
        if (!data_pend && data_left != 0 && data_rate > 0 && int'($urandom_range(99)) < data_rate) begin
            data_pend = 1'b1; data_we_v = 1'($urandom_range(1)); data_wstrb_v = 4'($urandom_range(15));
            data_addr_v = $urandom & 32'hFFFF_FFFC; data_wdata_v = $urandom;
            if (data_left > 0) data_left--;
        end
        inst_req = inst_pend; inst_addr = inst_addr_v;
        data_req = data_pend; data_we = data_we_v; data_wstrb = data_wstrb_v;
        data_addr = data_addr_v; data_wdata = data_wdata_v;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        if (mem_req === 1'b1) begin
            if (rdy_cnt == 0) mem_ready = 1'b1;
            else rdy_cnt--;
        end else if (stray_en && $urandom_range(7) == 0) begin
            mem_ready = 1'b1;
        end
        if (mem_wait) begin
            if (resp_cnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = rdata_fix_en ? rdata_fix : $urandom;
            end else begin
                resp_cnt--;
            end
        end else if (stray_en && $urandom_range(7) == 0) begin
            mem_valid = 1'b1; mem_rdata = $urandom;
        end
    endtask

    // Compare DUT outputs with the model, then advance the model by one cycle.
    task automatic check();
        logic exp_iv, exp_dv, gi, gd;
        exp_iv = (exp_inst_q.size() != 0);
        exp_dv = (exp_data_q.size() != 0);
        chk("inst_valid", inst_valid, exp_iv);
        chk("data_valid", data_valid, exp_dv);
        if (data_valid === 1'b1) n_dvalid++;
        if (bus_error === 1'b1) n_berr++;
        if (exp_iv) begin last_inst_rd = exp_inst_q.pop_front(); busy = 1'b0; lat_last = cyc - grant_cyc; end
        if (exp_dv) begin last_data_rd = exp_data_q.pop_front(); busy = 1'b0; lat_last = cyc - grant_cyc; end
        chk("inst_rdata", inst_rdata, last_inst_rd);
        chk("data_rdata", data_rdata, last_data_rd);
        chk("bus_error", bus_error, exp_berr);
        exp_berr = 1'b0;

        gi = !busy && inst_pend && (!data_pend || starve == STARVE_MAX);
        gd = !busy && data_pend && !gi;
        chk("inst_ready", inst_ready, gi);
        chk("data_ready", data_ready, gd);
        chk("starve_cnt", dbg_starve_cnt, starve);

        chk("mem_req", mem_req, exp_mem_req);
        if (exp_mem_req) begin
            mreq_cycles++;
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_we", mem_we, cur.we);
            chk("mem_wstrb", mem_wstrb, cur.wstrb);
            if (!cur.is_inst) chk("mem_wdata", mem_wdata, cur.wdata);
        end

        if (mem_wait) begin
            if (mem_valid) begin
                mem_wait = 1'b0;
                if (cur.is_inst) exp_inst_q.push_back(mem_rdata);
                else exp_data_q.push_back(mem_rdata);
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
                wcount++;
                if (wcount == TIMEOUT_CYCLES) begin
                    mem_wait = 1'b0; exp_berr = 1'b1;
                    if (cur.is_inst) exp_inst_q.push_back(32'h0000_0013);
                    else exp_data_q.push_back(32'h0);
                end
            end
`endif
        end

        if (exp_mem_req && mem_ready) begin
            exp_mem_req = 1'b0; mem_wait = 1'b1; wcount = 0;
            resp_cnt = pick_resp(); rdy_cnt = pick_rdy();
        end

        if (gi) begin
            starve = 0; busy = 1'b1; exp_mem_req = 1'b1; grant_cyc = cyc;
            cur = '{is_inst: 1'b1, we: 1'b0, wstrb: 4'h0, addr: inst_addr_v, wdata: '0};
            inst_pend = 1'b0;
            grant_log.push_back({1'b1, 4'(starve)});
        end else if (gd) begin
            if (inst_pend && starve < STARVE_MAX) starve++;
            busy = 1'b1; exp_mem_req = 1'b1; grant_cyc = cyc;
            cur = '{is_inst: 1'b0, we: data_we_v, wstrb: data_wstrb_v, addr: data_addr_v, wdata: data_wdata_v};
            data_pend = 1'b0;
            grant_log.push_back({1'b0, 4'(starve)});
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((busy || inst_pend || data_pend) && n < budget);
        chk("drain", {busy, inst_pend, data_pend}, 3'b000);
    endtask

    task automatic check_zero();
        chk("rst_inst_ready", inst_ready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_state_idle", dbg_state, 0);
        chk("rst_starve", dbg_starve_cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        // reset with requests pending: readies must stay low
        reset = 1'b0; inst_req = 1'b1; data_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1;
        reset = 1'b1;
        reset_model();

        // 1: single fetch, zero-wait memory
        rdy_fix = 0; resp_fix = 0; rdy_cnt = 0;
        rdata_fix_en = 1'b1; rdata_fix = 32'h0050_0093;
        post_inst(32'h40);
        run_until_idle(20);
        chk("t1_latency", lat_last, 3);
        chk("t1_inst_rdata", inst_rdata, 32'h0050_0093);
        rdata_fix_en = 1'b0;

        // 2: simultaneous fetch and load, data wins first
        grant_log.delete();
        post_inst(32'h44);
        post_data(1'b0, 4'h0, 32'h100, 32'h0);
        run_until_idle(20);
        chk("t2_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t2_first_data", grant_log[0], {1'b0, 4'd1});
            chk("t2_then_inst", grant_log[1], {1'b1, 4'd0});
        end

        // 3: data requester busy for 6 transactions, fetch forced after STARVE_MAX data grants
        grant_log.delete();
        data_rate = 100; data_left = 6;
        post_inst(32'h48);
        run_until_idle(60);
        data_rate = 0; data_left = 0;
        chk("t3_grants", grant_log.size(), 7);
        if (grant_log.size() == 7) begin
            chk("t3_g0", grant_log[0], {1'b0, 4'd1});
            chk("t3_g1", grant_log[1], {1'b0, 4'd2});
            chk("t3_g2", grant_log[2], {1'b0, 4'd3});
            chk("t3_g3", grant_log[3], {1'b0, 4'd4});
            chk("t3_g4_inst", grant_log[4], {1'b1, 4'd0});
            chk("t3_g5", grant_log[5], {1'b0, 4'd0});
            chk("t3_g6", grant_log[6], {1'b0, 4'd0});
        end

        // 4: store with mem_ready delayed 3 cycles
        rdy_fix = 3; rdy_cnt = 3; resp_fix = 1;
        mreq_cycles = 0; n_dvalid = 0;
        post_data(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
        run_until_idle(20);
        chk("t4_mreq_cycles", mreq_cycles, 4);
        chk("t4_dvalid_once", n_dvalid, 1);

        // randomized traffic
        rdy_fix = -1; resp_fix = -1; rdy_cnt = 0;
        inst_rate = 40; data_rate = 60; data_left = -1; stray_en = 1'b1;
        repeat (600) cycle();
        inst_rate = 0; data_rate = 0; data_left = 0; stray_en = 1'b0;
        run_until_idle(60);

        // 5: reset while waiting on a load, then a late mem_valid
        rdy_fix = 0; rdy_cnt = 0; resp_fix = 50;
        post_data(1'b0, 4'hF, 32'h300, 32'h0);
        n = 0;
        while (!mem_wait && n < 20) begin
            cycle();
            n++;
        end
        chk("t5_reached_wait", mem_wait, 1'b1);
        cycle();
        cycle();
        reset = 1'b0; inst_req = 1'b1; data_req = 1'b1; mem_ready = 1'b0; mem_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1;
        reset = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1;
        reset_model();

        // post-reset sanity fetch
        resp_fix = 0; rdy_fix = 0; rdy_cnt = 0;
        post_inst(32'h400);
        run_until_idle(20);

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: fetch whose response never arrives
        resp_fix = 100000; n_berr = 0;
        post_inst(32'h80);
        run_until_idle(60);
        chk("t6_bus_error_once", n_berr, 1);
        chk("t6_nop", inst_rdata, 32'h0000_0013);
        resp_fix = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
